button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter NBTN, default 5: number of buttons; bit order 0=left, 1=right, 2=up, 3=down, 4=center.
REQ-002 Parameter DB_CYC, default 400000: stable cycles required to accept an edge (10 ms at 40 MHz); legal range >= 1.
REQ-003 Parameter HOLD_CYC, default 20000000: cycles in PRESSED before hold asserts (0.5 s); legal only if HOLD_CYC > DB_CYC.
REQ-004 clk  input  1  single clock, the pixel clock of the 600p timing; all logic on rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low (rst=0 resets).
REQ-006 btn_raw  input  NBTN  raw, asynchronous, bouncing pushbutton levels; 1 = pressed.
REQ-007 btn  output  NBTN  debounced level per button.
REQ-008 btn_dn  output  NBTN  one-cycle pulse on each accepted press.
REQ-009 btn_up  output  NBTN  one-cycle pulse on each accepted release.
REQ-010 btn_hold  output  NBTN  level; 1 while the button has been debounced-pressed for >= HOLD_CYC cycles.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer; the second flop output is "s" below.
REQ-012 Each button SHALL have an independent FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a debounce counter and a hold counter of width $clog2(HOLD_CYC+1).
REQ-013 RELEASED: s=1 -> PRESS_WAIT, debounce counter cleared; else stay.
REQ-014 PRESS_WAIT: s=0 -> RELEASED (bounce rejected, no output change); s=1 -> counter increments; when the counter reaches DB_CYC-1 with s=1 -> PRESSED.
REQ-015 Entering PRESSED from PRESS_WAIT SHALL set btn=1, pulse btn_dn for exactly that one cycle, and clear the hold counter.
REQ-016 PRESSED: hold counter increments and saturates at HOLD_CYC; btn_hold=1 from the cycle after it reaches HOLD_CYC; s=0 -> RELEASE_WAIT, debounce counter cleared.
REQ-017 RELEASE_WAIT: s=1 -> PRESSED with no btn_dn pulse and the hold counter preserved; s=0 for DB_CYC consecutive cycles -> RELEASED.
REQ-018 Entering RELEASED from RELEASE_WAIT SHALL set btn=0 and btn_hold=0, and pulse btn_up for exactly that cycle.
REQ-019 btn SHALL remain 1 through PRESSED and RELEASE_WAIT, and remain 0 through RELEASED and PRESS_WAIT.
REQ-020 All outputs SHALL be registered; for a clean raw edge, btn and its pulse SHALL change exactly DB_CYC+2 rising edges after the first edge that samples the new raw level.
REQ-021 The hold counter SHALL count through RELEASE_WAIT; the hold counter and btn_hold SHALL change only in PRESSED and RELEASE_WAIT.
REQ-022 Buttons SHALL be fully independent; simultaneous edges on several bits SHALL produce simultaneous pulses with no priority.
REQ-023 btn_dn and btn_up SHALL never both be 1 for the same bit in the same cycle.

Reset
REQ-024 rst=0 SHALL immediately clear the synchronizers, counters, btn, btn_dn, btn_up and btn_hold to 0, and force every FSM to RELEASED.
REQ-025 Reset asserted mid-press SHALL emit no btn_up pulse.
REQ-026 After reset deassertion, a button held throughout SHALL be accepted as a fresh press after DB_CYC+2 cycles, with btn_dn pulsing once.

Verification (bench parameters DB_CYC=4, HOLD_CYC=16)
REQ-027 btn_raw[0] 0->1 at edge 0, then held -> btn[0]=1 and btn_dn[0]=1 at edge 6 only; btn_dn low at edge 7.
REQ-028 btn_raw[4] toggled 1,0,1,0 every 2 cycles, then 0 -> btn[4], btn_dn[4] and btn_up[4] stay 0 throughout.
REQ-029 btn_raw[2] held 30 cycles, then released -> btn_hold[2]=1 from edge 6+16+1=23; at release, btn_up[2] pulses once DB_CYC+2 cycles after the raw fall, with btn_hold[2]=0 in the same cycle.
REQ-030 Pressed button with a 2-cycle low glitch -> no btn_up or btn_dn pulse; btn stays 1; the hold count is uninterrupted.
REQ-031 btn_raw[1:0]=2'b11 applied in the same cycle -> btn_dn[1:0]=2'b11 in the same cycle.
REQ-032 rst pulsed low while btn[3]=1 -> all outputs 0 asynchronously, no btn_up pulse; with raw still high after reset, btn_dn[3] pulses at edge 6 after reset release.

Source files
------------

// File: rtl/button_debounce.sv
// Multi-button debouncer with press/release pulses and long-hold detection.
// Each raw input is synchronised, then filtered by an independent
// four-state FSM that requires DB_CYC stable cycles before accepting an edge.
module button_debounce #(
    parameter int unsigned NBTN     = 5,
    parameter int unsigned DB_CYC   = 400000,
    parameter int unsigned HOLD_CYC = 20000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_dn,
    output logic [NBTN-1:0] btn_up,
    output logic [NBTN-1:0] btn_hold
);

    // Debounce counter only has to reach DB_CYC-1; keep at least one bit.
    localparam int unsigned DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;

    // Two-flop synchroniser for the asynchronous pushbutton levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        state_t        state;
        state_t        state_nx;
        logic [DW-1:0] db_cnt;
        logic [DW-1:0] db_cnt_nx;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_cnt_nx;
        logic [HW-1:0] hold_inc;
        logic          s;
        logic          lvl_q;
        logic          lvl_nx;
        logic          dn_q;
        logic          dn_nx;
        logic          up_q;
        logic          up_nx;
        logic          hold_q;
        logic          hold_nx;

        assign s = sync2[i];

        // State, counters and registered outputs for this button.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state    <= RELEASED;
                db_cnt   <= '0;
                hold_cnt <= '0;
                lvl_q    <= 1'b0;
                dn_q     <= 1'b0;
                up_q     <= 1'b0;
                hold_q   <= 1'b0;
            end else begin
                state    <= state_nx;
                db_cnt   <= db_cnt_nx;
                hold_cnt <= hold_cnt_nx;
                lvl_q    <= lvl_nx;
                dn_q     <= dn_nx;
                up_q     <= up_nx;
                hold_q   <= hold_nx;
            end
        end

        // Next-state, counter and output decode; pulses default low each cycle.
        always_comb begin
            state_nx    = state;
            db_cnt_nx   = db_cnt;
            hold_cnt_nx = hold_cnt;
            lvl_nx      = lvl_q;
            dn_nx       = 1'b0;
            up_nx       = 1'b0;
            hold_nx     = hold_q;
            hold_inc    = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);

            case (state)
                RELEASED: begin
                    if (s) begin
                        state_nx  = PRESS_WAIT;
                        db_cnt_nx = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_nx = RELEASED;
                    end else if (db_cnt == DB_LAST) begin
                        state_nx    = PRESSED;
                        lvl_nx      = 1'b1;
                        dn_nx       = 1'b1;
                        hold_cnt_nx = '0;
                    end else begin
                        db_cnt_nx = db_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    hold_cnt_nx = hold_inc;
                    hold_nx     = (hold_cnt == HOLD_MAX);
                    if (!s) begin
                        state_nx  = RELEASE_WAIT;
                        db_cnt_nx = '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Hold keeps counting so a short glitch does not restart it.
                    hold_cnt_nx = hold_inc;
                    hold_nx     = (hold_cnt == HOLD_MAX);
                    if (s) begin
                        state_nx = PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state_nx = RELEASED;
                        lvl_nx   = 1'b0;
                        up_nx    = 1'b1;
                        hold_nx  = 1'b0;
                    end else begin
                        db_cnt_nx = db_cnt + DW'(1);
                    end
                end
                default: begin
                    state_nx = RELEASED;
                end
            endcase
        end

        assign btn[i]      = lvl_q;
        assign btn_dn[i]   = dn_q;
        assign btn_up[i]   = up_q;
        assign btn_hold[i] = hold_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce with DB_CYC=4, HOLD_CYC=16.
// Tasks push expected output values tagged with the cycle they are due;
// a negedge monitor pops and compares them as the cycle counter reaches them.
module tb_button_debounce;

    localparam int F_BTN  = 0;
    localparam int F_DN   = 1;
    localparam int F_UP   = 2;
    localparam int F_HOLD = 3;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn;
    logic [4:0] btn_dn;
    logic [4:0] btn_up;
    logic [4:0] btn_hold;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        int         fld;
        logic [4:0] mask;
        logic [4:0] val;
        string      name;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [4:0] act;

    button_debounce #(
        .NBTN    (5),
        .DB_CYC  (4),
        .HOLD_CYC(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn     (btn),
        .btn_dn  (btn_dn),
        .btn_up  (btn_up),
        .btn_hold(btn_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Insert an expectation keeping the queue ordered by due cycle.
    function automatic void ex(int c, int f, logic [4:0] m, logic [4:0] v, string n);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.fld  = f;
        e.mask = m;
        e.val  = v;
        e.name = n;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endfunction

    // Scoreboard compare point plus the press/release exclusivity invariant.
    always @(negedge clk) begin
        checks++;
        if ((btn_dn & btn_up) !== 5'b0) begin
            errors++;
            $display("FAIL dn_up_exclusive cyc=%0d dn=%b up=%b required no common bit", cyc, btn_dn, btn_up);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            case (cur.fld)
                F_BTN:   act = btn;
                F_DN:    act = btn_dn;
                F_UP:    act = btn_up;
                default: act = btn_hold;
            endcase
            checks++;
            if ((act & cur.mask) !== (cur.val & cur.mask)) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%b required=%b mask=%b", cur.name, cyc, act, cur.val, cur.mask);
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({btn, btn_dn, btn_up, btn_hold} !== 20'b0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=0", {btn, btn_dn, btn_up, btn_hold});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            ex(cyc + k, F_BTN,  5'h1f, 5'b0, "post_reset_btn");
            ex(cyc + k, F_DN,   5'h1f, 5'b0, "post_reset_dn");
            ex(cyc + k, F_UP,   5'h1f, 5'b0, "post_reset_up");
            ex(cyc + k, F_HOLD, 5'h1f, 5'b0, "post_reset_hold");
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_press();
        int n;
        @(negedge clk);
        n = cyc;
        btn_raw[0] = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            ex(n + 1 + k, F_BTN, 5'b00001, 5'b0, "press_btn_early");
            ex(n + 1 + k, F_DN,  5'b00001, 5'b0, "press_dn_early");
        end
        ex(n + 7, F_BTN, 5'b00001, 5'b00001, "press_btn_edge6");
        ex(n + 7, F_DN,  5'b00001, 5'b00001, "press_dn_edge6");
        ex(n + 7, F_BTN, 5'b11110, 5'b0,     "press_other_bits");
        ex(n + 8, F_DN,  5'b00001, 5'b0,     "press_dn_edge7");
        ex(n + 8, F_BTN, 5'b00001, 5'b00001, "press_btn_edge7");
        repeat (10) @(negedge clk);
        n = cyc;
        btn_raw[0] = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            ex(n + 1 + k, F_BTN, 5'b00001, 5'b00001, "release_btn_early");
            ex(n + 1 + k, F_UP,  5'b00001, 5'b0,     "release_up_early");
        end
        ex(n + 7, F_BTN,  5'b00001, 5'b0,     "release_btn_edge6");
        ex(n + 7, F_UP,   5'b00001, 5'b00001, "release_up_edge6");
        ex(n + 7, F_HOLD, 5'b00001, 5'b0,     "short_press_no_hold");
        ex(n + 8, F_UP,   5'b00001, 5'b0,     "release_up_edge7");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        int n;
        @(negedge clk);
        n = cyc;
        for (int k = 1; k <= 20; k++) begin
            ex(n + k, F_BTN, 5'b10000, 5'b0, "bounce_btn");
            ex(n + k, F_DN,  5'b10000, 5'b0, "bounce_dn");
            ex(n + k, F_UP,  5'b10000, 5'b0, "bounce_up");
        end
        btn_raw[4] = 1'b1;
        repeat (2) @(negedge clk);
        btn_raw[4] = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw[4] = 1'b1;
        repeat (2) @(negedge clk);
        btn_raw[4] = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_hold();
        int n;
        int m;
        @(negedge clk);
        n = cyc;
        btn_raw[2] = 1'b1;
        ex(n + 7,  F_DN,   5'b00100, 5'b00100, "hold_dn");
        ex(n + 23, F_HOLD, 5'b00100, 5'b0,     "hold_edge22_low");
        ex(n + 24, F_HOLD, 5'b00100, 5'b00100, "hold_edge23_high");
        ex(n + 30, F_HOLD, 5'b00100, 5'b00100, "hold_stays");
        repeat (30) @(negedge clk);
        m = cyc;
        btn_raw[2] = 1'b0;
        for (int k = 2; k <= 5; k++)
            ex(m + 1 + k, F_HOLD, 5'b00100, 5'b00100, "hold_in_release_wait");
        ex(m + 6, F_BTN,  5'b00100, 5'b00100, "hold_btn_before_up");
        ex(m + 6, F_UP,   5'b00100, 5'b0,     "hold_up_early");
        ex(m + 7, F_UP,   5'b00100, 5'b00100, "hold_up_edge6");
        ex(m + 7, F_HOLD, 5'b00100, 5'b0,     "hold_clear_with_up");
        ex(m + 7, F_BTN,  5'b00100, 5'b0,     "hold_btn_released");
        ex(m + 8, F_UP,   5'b00100, 5'b0,     "hold_up_once");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        int n;
        int m;
        @(negedge clk);
        n = cyc;
        btn_raw[0] = 1'b1;
        ex(n + 7, F_DN, 5'b00001, 5'b00001, "glitch_press_dn");
        repeat (10) @(negedge clk);
        btn_raw[0] = 1'b0;
        for (int c = n + 11; c <= n + 30; c++) begin
            ex(c, F_BTN, 5'b00001, 5'b00001, "glitch_btn_held");
            ex(c, F_DN,  5'b00001, 5'b0,     "glitch_no_dn");
            ex(c, F_UP,  5'b00001, 5'b0,     "glitch_no_up");
        end
        ex(n + 23, F_HOLD, 5'b00001, 5'b0,     "glitch_hold_edge22");
        ex(n + 24, F_HOLD, 5'b00001, 5'b00001, "glitch_hold_edge23");
        repeat (2) @(negedge clk);
        btn_raw[0] = 1'b1;
        repeat (18) @(negedge clk);
        m = cyc;
        btn_raw[0] = 1'b0;
        ex(m + 7, F_UP, 5'b00001, 5'b00001, "glitch_final_up");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int n;
        @(negedge clk);
        n = cyc;
        btn_raw[1:0] = 2'b11;
        ex(n + 6, F_BTN, 5'b00011, 5'b0,     "simul_btn_early");
        ex(n + 7, F_BTN, 5'b00011, 5'b00011, "simul_btn");
        ex(n + 7, F_DN,  5'b00011, 5'b00011, "simul_dn");
        ex(n + 8, F_DN,  5'b00011, 5'b0,     "simul_dn_once");
        repeat (10) @(negedge clk);
        n = cyc;
        btn_raw[1:0] = 2'b00;
        ex(n + 7, F_UP,  5'b00011, 5'b00011, "simul_up");
        ex(n + 7, F_BTN, 5'b00011, 5'b0,     "simul_btn_rel");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_press();
        int n;
        @(negedge clk);
        n = cyc;
        btn_raw[3] = 1'b1;
        ex(n + 7, F_DN,  5'b01000, 5'b01000, "rstmid_first_dn");
        ex(n + 9, F_BTN, 5'b01000, 5'b01000, "rstmid_btn_before");
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({btn, btn_dn, btn_up, btn_hold} !== 20'b0) begin
            errors++;
            $display("FAIL rstmid_async_clear actual=%b required=0", {btn, btn_dn, btn_up, btn_hold});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ((btn_up | btn) !== 5'b0) begin
                errors++;
                $display("FAIL rstmid_during_reset up=%b btn=%b required 0", btn_up, btn);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        n = cyc;
        for (int k = 1; k <= 6; k++) begin
            ex(n + k, F_BTN, 5'b01000, 5'b0, "rstmid_btn_early");
            ex(n + k, F_DN,  5'b01000, 5'b0, "rstmid_dn_early");
        end
        for (int k = 1; k <= 8; k++)
            ex(n + k, F_UP, 5'b01000, 5'b0, "rstmid_no_up");
        ex(n + 7, F_DN,  5'b01000, 5'b01000, "rstmid_fresh_dn");
        ex(n + 7, F_BTN, 5'b01000, 5'b01000, "rstmid_fresh_btn");
        ex(n + 8, F_DN,  5'b01000, 5'b0,     "rstmid_dn_once");
        repeat (10) @(negedge clk);
        n = cyc;
        btn_raw[3] = 1'b0;
        ex(n + 7, F_UP, 5'b01000, 5'b01000, "rstmid_release_up");
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        btn_raw = 5'b0;
        test_reset();
        test_press();
        test_bounce();
        test_hold();
        test_glitch();
        test_simultaneous();
        test_reset_mid_press();
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
